// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for a 4-digit multiplexed seven-segment display.
//   It samples the anode and segment lines and waits for each digit dwell
//   to be stable. Each accepted dwell is decoded back into a hex nibble, a
//   decimal point and a blank flag. Once all four digits have been seen, the
//   complete frame is published together with a one-cycle frame_valid pulse.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   an_in[3:0]   anode lines, active-low (an_in[i] low selects digit i)
//   sseg_in[7:0] segment lines, active-low; [7]=dp, [6:0]={g,f,e,d,c,b,a}
//   hex_out      committed digits; nibble [4i+3:4i] belongs to digit i
//   dp_out       committed decimal points, active-high
//   blank_out    committed blank flags (digit had all segments off)
//   frame_valid  one-cycle pulse when hex_out/dp_out/blank_out update
//   seg_err      one-cycle pulse: accepted dwell had an undecodable pattern
//   an_err       one-cycle pulse: accepted dwell had more than one anode low
//   err_cnt      saturating count of seg_err and an_err events

module seg_scan_decoder #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_in,
    input  logic [7:0]  sseg_in,
    output logic [15:0] hex_out,
    output logic [3:0]  dp_out,
    output logic [3:0]  blank_out,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic [7:0]  err_cnt
);

    localparam int CW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HELD} state_t;

    // Decode result: {hit, blank, nibble}. A pattern outside the table gives hit=0.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40: decode = {2'b10, 4'h0};
            7'h79: decode = {2'b10, 4'h1};
            7'h24: decode = {2'b10, 4'h2};
            7'h30: decode = {2'b10, 4'h3};
            7'h19: decode = {2'b10, 4'h4};
            7'h12: decode = {2'b10, 4'h5};
            7'h02: decode = {2'b10, 4'h6};
            7'h78: decode = {2'b10, 4'h7};
            7'h00: decode = {2'b10, 4'h8};
            7'h10: decode = {2'b10, 4'h9};
            7'h08: decode = {2'b10, 4'hA};
            7'h03: decode = {2'b10, 4'hB};
            7'h46: decode = {2'b10, 4'hC};
            7'h21: decode = {2'b10, 4'hD};
            7'h06: decode = {2'b10, 4'hE};
            7'h0E: decode = {2'b10, 4'hF};
            7'h7F: decode = {2'b11, 4'h0};
            default: decode = 6'b0;
        endcase
    endfunction

    logic [3:0]    r_an_s1, r_an_s2, r_an_prev;
    logic [7:0]    r_sseg_s1, r_sseg_s2, r_sseg_prev;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_diff, w_accept;

    logic [3:0]  r_seen, w_seen_upd;
    logic [15:0] r_sh_hex, w_sh_hex;
    logic [3:0]  r_sh_dp, w_sh_dp, r_sh_blank, w_sh_blank;
    logic [15:0] r_hex;
    logic [3:0]  r_dp, r_blank;
    logic        r_fv, r_seg_err, r_an_err;
    logic [7:0]  r_err_cnt;

    logic [5:0]  w_dec;
    logic        w_an_idle, w_an_one, w_digit_ok, w_seg_bad, w_an_bad, w_commit;

    // Two-flop synchronizer followed by the previous-pair register that the
    // stability FSM compares against.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples values from before the edge, whatever the statement order.
        if (rst) begin
            r_an_s1     <= 4'hF;
            r_an_s2     <= 4'hF;
            r_an_prev   <= 4'hF;
            r_sseg_s1   <= 8'hFF;
            r_sseg_s2   <= 8'hFF;
            r_sseg_prev <= 8'hFF;
        end else begin
            r_an_s1     <= an_in;
            r_an_s2     <= r_an_s1;
            r_an_prev   <= r_an_s2;
            r_sseg_s1   <= sseg_in;
            r_sseg_s2   <= r_sseg_s1;
            r_sseg_prev <= r_sseg_s2;
        end
    end

    assign w_diff = {r_an_s2, r_sseg_s2} != {r_an_prev, r_sseg_prev};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The accept fires from S_COUNT only when the count has reached STABLE_CYC
    // and the pair is still unchanged. That makes the minimum accepted dwell
    // at the pins STABLE_CYC+1 cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_diff) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_COUNT: begin
                if (w_diff) begin
                    w_cnt_nxt = CW'(1);
                end else if (r_cnt == CW'(STABLE_CYC)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HELD: begin
                if (w_diff) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Classify the accepted pair. When the pair is stable, the s2 stage holds it.
    assign w_dec      = decode(r_sseg_s2[6:0]);
    assign w_an_idle  = (r_an_s2 == 4'hF);
    assign w_an_one   = $onehot(~r_an_s2);
    assign w_digit_ok = w_accept && w_an_one && w_dec[5];
    assign w_seg_bad  = w_accept && w_an_one && !w_dec[5];
    assign w_an_bad   = w_accept && !w_an_idle && !w_an_one;
    assign w_seen_upd = w_digit_ok ? (r_seen | ~r_an_s2) : r_seen;
    assign w_commit   = w_digit_ok && (w_seen_upd == 4'hF);

    // Next shadow value, including the digit being accepted now. A completing
    // digit is committed to the outputs in the same cycle it is written.
    always_comb begin
        w_sh_hex   = r_sh_hex;
        w_sh_dp    = r_sh_dp;
        w_sh_blank = r_sh_blank;
        if (w_digit_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (!r_an_s2[i]) begin
                    w_sh_hex[4*i +: 4] = w_dec[3:0];
                    w_sh_dp[i]         = ~r_sseg_s2[7];
                    w_sh_blank[i]      = w_dec[4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the shadow digits are reset as well. A reset in the middle of a
        // frame must discard partial data, so none of it can leak into the
        // next commit.
        if (rst) begin
            r_seen     <= '0;
            r_sh_hex   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_hex      <= '0;
            r_dp       <= '0;
            r_blank    <= 4'hF;
            r_fv       <= 1'b0;
            r_seg_err  <= 1'b0;
            r_an_err   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_seen     <= w_commit ? 4'h0 : w_seen_upd;
            r_sh_hex   <= w_sh_hex;
            r_sh_dp    <= w_sh_dp;
            r_sh_blank <= w_sh_blank;
            if (w_commit) begin
                r_hex   <= w_sh_hex;
                r_dp    <= w_sh_dp;
                r_blank <= w_sh_blank;
            end
            r_fv      <= w_commit;
            r_seg_err <= w_seg_bad;
            r_an_err  <= w_an_bad;
            // Only one of the error sources can fire per accept, so the count
            // rises by at most one per cycle.
            if ((w_seg_bad || w_an_bad) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign hex_out     = r_hex;
    assign dp_out      = r_dp;
    assign blank_out   = r_blank;
    assign frame_valid = r_fv;
    assign seg_err     = r_seg_err;
    assign an_err      = r_an_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Scoreboard bench for seg_scan_decoder (STABLE_CYC = 4). The stimulus
//   thread scans digit dwells and queues each frame it expects. A negedge
//   monitor pops the queue and compares it on every frame_valid pulse, and
//   it also counts the error pulses.

module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_in;
    logic [7:0]  sseg_in;
    logic [15:0] hex_out;
    logic [3:0]  dp_out, blank_out;
    logic        frame_valid, seg_err, an_err;
    logic [7:0]  err_cnt;

    seg_scan_decoder #(.STABLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .an_in(an_in), .sseg_in(sseg_in),
        .hex_out(hex_out), .dp_out(dp_out), .blank_out(blank_out),
        .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        int          cyc;   // required edge number of the pulse, -1 = any
    } frame_t;

    frame_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_frames = 0;
    int n_seg = 0;
    int n_an  = 0;
    logic prev_fv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares each published frame with the head of the queue.
    always @(negedge clk) begin
        if (seg_err) n_seg <= n_seg + 1;
        if (an_err)  n_an  <= n_an + 1;
        if (seg_err && an_err) check("err_exclusive", {30'b0, seg_err, an_err}, 32'd2);
        if (frame_valid) begin
            n_frames <= n_frames + 1;
            check("fv_width", {31'b0, prev_fv}, 32'd0);
            if (q.size() == 0) begin
                check("fv_unexpected", 32'd1, 32'd0);
            end else begin
                frame_t e;
                e = q.pop_front();
                check("hex_out", {16'b0, hex_out}, {16'b0, e.hex});
                check("dp_out", {28'b0, dp_out}, {28'b0, e.dp});
                check("blank_out", {28'b0, blank_out}, {28'b0, e.blank});
                if (e.cyc >= 0) check("fv_latency", cyc, e.cyc);
            end
        end
        prev_fv <= frame_valid;
    end

    // Called right after a posedge. The pins are sampled at the next n edges.
    task automatic dwell(input logic [3:0] an, input logic [7:0] sseg, input int n);
        an_in   = an;
        sseg_in = sseg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int i, input logic [6:0] seg, input logic dp, input int n);
        logic [3:0] an;
        an = 4'hF;
        an[i] = 1'b0;
        dwell(an, {~dp, seg}, n);
    endtask

    task automatic expect_frame(input logic [15:0] h, input logic [3:0] d,
                                input logic [3:0] b, input int c);
        frame_t f;
        f.hex = h; f.dp = d; f.blank = b; f.cyc = c;
        q.push_back(f);
    endtask

    int an_base;

    initial begin
        rst = 1'b1; an_in = 4'hF; sseg_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hex", {16'b0, hex_out}, 32'h0);
        check("rst_dp", {28'b0, dp_out}, 32'h0);
        check("rst_blank", {28'b0, blank_out}, 32'hF);
        check("rst_fv", {31'b0, frame_valid}, 32'h0);
        check("rst_errcnt", {24'b0, err_cnt}, 32'h0);
        rst = 1'b0;
        dwell(4'hF, 8'hFF, 4);

        // Full frame: the pulse must land at edge E0+S+2 of the digit-3 dwell.
        digit(0, 7'h40, 1'b0, 8);
        digit(1, 7'h79, 1'b0, 8);
        digit(2, 7'h24, 1'b0, 8);
        expect_frame(16'h3210, 4'b1000, 4'b0000, cyc + 1 + S + 2);
        digit(3, 7'h30, 1'b1, 8);
        dwell(4'hF, 8'hFF, 8);
        check("frames_full", n_frames, 1);

        // Glitch: a 4-cycle dwell of digit 1 is below the minimum and is ignored.
        digit(0, 7'h40, 1'b0, 8);
        digit(1, 7'h79, 1'b0, 4);
        digit(2, 7'h24, 1'b0, 8);
        digit(3, 7'h30, 1'b0, 8);
        check("frames_glitch", n_frames, 1);
        expect_frame(16'h3210, 4'b0000, 4'b0000, -1);
        digit(1, 7'h79, 1'b0, 8);
        check("frames_glitch_done", n_frames, 2);
        check("errs_glitch", n_seg + n_an, 0);

        // Bad pattern on digit 2.
        digit(0, 7'h40, 1'b0, 8);
        digit(1, 7'h79, 1'b0, 8);
        digit(2, 7'h7E, 1'b0, 8);
        check("seg_err_pulses", n_seg, 1);
        check("errcnt_seg", {24'b0, err_cnt}, 32'd1);
        digit(3, 7'h30, 1'b0, 8);
        check("frames_badpat", n_frames, 2);
        expect_frame(16'h3210, 4'b0000, 4'b0000, -1);
        digit(2, 7'h24, 1'b0, 8);
        check("frames_badpat_done", n_frames, 3);

        // Multiple anodes: error only, shadow untouched.
        digit(0, 7'h12, 1'b0, 8);
        digit(1, 7'h02, 1'b0, 8);
        dwell(4'b1100, 8'hC0, 8);
        check("an_err_pulses", n_an, 1);
        check("errcnt_an", {24'b0, err_cnt}, 32'd2);
        digit(2, 7'h78, 1'b0, 8);
        expect_frame(16'h8765, 4'b0000, 4'b0000, -1);
        digit(3, 7'h00, 1'b0, 8);
        check("frames_multi", n_frames, 4);

        // Blank digit and overwrite of digit 0.
        digit(2, 7'h7F, 1'b0, 8);
        digit(0, 7'h40, 1'b0, 8);
        digit(0, 7'h12, 1'b0, 8);
        digit(1, 7'h79, 1'b0, 8);
        expect_frame(16'h3015, 4'b1000, 4'b0100, -1);
        digit(3, 7'h30, 1'b1, 8);
        check("frames_blank", n_frames, 5);
        check("blank2_held", {31'b0, blank_out[2]}, 32'd1);
        check("digit0_last_wins", {28'b0, hex_out[3:0]}, 32'h5);

        // Reset mid-frame.
        digit(0, 7'h40, 1'b0, 8);
        digit(1, 7'h79, 1'b0, 8);
        rst = 1'b1; an_in = 4'hF; sseg_in = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_hex", {16'b0, hex_out}, 32'h0);
        check("midrst_blank", {28'b0, blank_out}, 32'hF);
        check("midrst_errcnt", {24'b0, err_cnt}, 32'h0);
        digit(2, 7'h24, 1'b0, 8);
        digit(3, 7'h30, 1'b0, 8);
        dwell(4'hF, 8'hFF, 8);
        check("frames_midrst", n_frames, 5);
        check("midrst_hex_held", {16'b0, hex_out}, 32'h0);
        expect_frame(16'h3210, 4'b0000, 4'b0000, -1);
        digit(0, 7'h40, 1'b0, 8);
        digit(1, 7'h79, 1'b0, 8);
        check("frames_after_rst", n_frames, 6);

        // Saturation, using minimum-length (S+1) alternating multi-anode dwells.
        an_base = n_an;
        for (int k = 0; k < 255; k++)
            dwell(k[0] ? 4'b1010 : 4'b1100, 8'hFF, S + 1);
        dwell(4'hF, 8'hFF, 8);
        check("errcnt_255", {24'b0, err_cnt}, 32'd255);
        for (int k = 0; k < 5; k++)
            dwell(k[0] ? 4'b1010 : 4'b1100, 8'hFF, S + 1);
        dwell(4'hF, 8'hFF, 8);
        check("errcnt_sat", {24'b0, err_cnt}, 32'd255);
        check("an_pulses_sat", n_an - an_base, 260);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the multiplexed seven-segment interface driven by `seg_display`. It samples the anode and segment lines of a 4-digit scanned display and filters each digit dwell for stability. Each accepted dwell is decoded back to a hex nibble plus decimal point, and a complete 4-digit frame is published with a one-cycle valid strobe. It is used for board-to-board loopback checks and for self-checking benches of the display path (`sw_BCD` → `seg_display`).

## Interface
- `STABLE_CYC`, default 4: consecutive identical synchronized samples of {an, sseg} required to accept a digit; legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `an_in`  in  4  anode lines, active-low; `an_in[i]` low selects digit i.
- `sseg_in`  in  8  segment lines, active-low; `[7]`=dp, `[6:0]`={g,f,e,d,c,b,a}.
- `hex_out`  out  16  committed digits; nibble `[4i+3:4i]` belongs to digit i.
- `dp_out`  out  4  committed decimal points, active-high.
- `blank_out`  out  4  committed blank flags; digit had all segments off.
- `frame_valid`  out  1  one-cycle pulse when `hex_out`, `dp_out` and `blank_out` update.
- `seg_err`  out  1  one-cycle pulse when an accepted dwell has an undecodable pattern.
- `an_err`  out  1  one-cycle pulse when an accepted dwell has more than one anode low.
- `err_cnt`  out  8  saturating count of `seg_err` and `an_err` events; saturates at 255.

## Operation
- **Input synchronizer:** `an_in` and `sseg_in` pass through a 2-flop synchronizer. Reset value is an=4'hF, sseg=8'hFF, i.e. idle.
- **Stability FSM:** compares the synchronized pair against the previous synchronized pair. States:
  - S_WAIT: pair differs → S_COUNT, cnt=1.
  - S_COUNT: pair differs → cnt=1 and stay in S_COUNT. Pair equal → cnt+1. When cnt reaches STABLE_CYC → accept the dwell and go to S_HELD.
  - S_HELD: pair differs → S_COUNT, cnt=1. Pair equal → stay; no re-accept.
- **Counter width:** clog2(STABLE_CYC+1).
- **Accepted dwell with an=4'hF:** no action. Inter-digit blanking is legal.
- **Accepted dwell with more than one anode low:** pulse `an_err`, increment `err_cnt`, change no shadow state.
- **Accepted dwell with exactly one anode low (digit i):** decode sseg[6:0] with this active-low table:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - 7F = blank: nibble 0, blank flag 1.
- **Decode result:**
  - Match: write nibble, `~sseg[7]` and the blank flag into shadow digit i, then set seen[i].
  - No match: pulse `seg_err`, increment `err_cnt`, leave shadow and seen unchanged.
- **Frame commit:** when an accept makes seen==4'hF:
  - copy shadow, including the digit just accepted, into `hex_out`/`dp_out`/`blank_out`;
  - pulse `frame_valid`;
  - clear seen.
- **Re-accepted digit:** accepting a digit whose seen bit is already set overwrites its shadow. The last value wins.
- **Error events:** `seg_err` and `an_err` are mutually exclusive in one cycle. `err_cnt` increments by at most 1 per cycle.

## Timing
- **Reset values:**
  - `hex_out`=0, `dp_out`=0, `blank_out`=4'hF;
  - `frame_valid`=0, `seg_err`=0, `an_err`=0, `err_cnt`=0;
  - seen=0, shadow=0, FSM=S_WAIT, cnt=0.
- **Accept latency:** let a new input pair first be sampled at edge E0, then held. The accept effects land at edge E0+STABLE_CYC+2. These effects are the shadow/seen write, `seg_err` or `an_err`, and, for a completing digit, the `hex_out` update together with `frame_valid`.
- **Minimum dwell:** the pair must be stable for STABLE_CYC+1 cycles at the pins to be accepted. Shorter dwells are ignored silently.
- **Minimum frame period:** 4×(STABLE_CYC+1) cycles.
- **Output stability:** outputs hold their value between `frame_valid` pulses. All pulse outputs are exactly 1 cycle wide.
- **Reset mid-frame:** discards seen and shadow. The next frame requires all four digits again. Committed outputs return to reset values.
- **`err_cnt` at 255:** holds at 255. Error pulses still fire.

## Test plan
- **Full frame:** STABLE_CYC=4. Scan an=1110/1101/1011/0111 with sseg={1,40},{1,79},{1,24},{0,30}, 8-cycle dwell each.
  - Expect one `frame_valid` with `hex_out`=16'h3210, `dp_out`=4'b1000, `blank_out`=0.
  - The pulse lands at edge E0+6 of the digit-3 dwell.
- **Glitch reject:** insert a 4-cycle dwell of digit 1=79 between valid dwells.
  - Expect no seen update, no `frame_valid`, no error pulse.
- **Bad pattern:** digit 2 dwell with sseg[6:0]=7E, 8 cycles.
  - Expect exactly one `seg_err` pulse, `err_cnt`=1, no `frame_valid` until digit 2 is resent as 24.
- **Multi-anode:** an=4'b1100 for 8 cycles.
  - Expect one `an_err` pulse, `err_cnt` increments, shadow unchanged.
- **Blank and overwrite:** send digit 2 as 7F, then digit 0 twice (40, then 12), then digits 1 and 3.
  - Expect `blank_out`[2]=1, `hex_out`[11:8]=0, `hex_out`[3:0]=5, one `frame_valid`.
- **Reset mid-frame:** assert `rst` for 1 cycle after digits 0 and 1 are accepted, then send digits 2 and 3 only.
  - Expect no `frame_valid` and `hex_out`=0.
  - Sending digits 0 and 1 afterwards produces `frame_valid`.
